// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment scan path: glyph ROM, scan states
// and the digit-strobe helper.
package seg_disp_pkg;

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs, bit0 = segment a, bit6 = segment g.
  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [15:0] f_onehot(input logic [3:0] idx);
    f_onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Code-to-glyph decoder; output is active-high, polarity is the caller's job.
module seg_glyph_dec
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_hex_en,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = GLYPH_TAB[i_code];
    if ((i_code > 4'd9) && !i_hex_en) o_glyph = SEG_BLANK;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with inter-digit blanking gap,
// per-digit blink, leading-zero suppression and optional hex glyphs.
module seg_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIG      = 6,
  parameter int DWELL_TICKS  = 1,
  parameter int GAP_CYC      = 2,
  parameter int BLINK_TICKS  = 250,
  parameter int HEX_EN       = 0,
  parameter int SEG_ACT_LOW  = 1,
  parameter int SCAN_ACT_LOW = 1
) (
  input  logic                 SYS_CLK,
  input  logic                 EXT_RST_N,
  input  logic                 MS_F,
  input  logic [4*NUM_DIG-1:0] DIGIT_VAL,
  input  logic [NUM_DIG-1:0]   DP_IN,
  input  logic [NUM_DIG-1:0]   BLINK_MASK,
  input  logic                 LZ_EN,
  output logic [NUM_DIG-1:0]   SCAN,
  output logic [6:0]           SEVEN_SEG,
  output logic                 DISP_DP
);

  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int GAP_W = ($clog2(GAP_CYC + 1) < 1) ? 1 : $clog2(GAP_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [15:0]      BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic             SEG_INV    = (SEG_ACT_LOW != 0);
  localparam logic             SCAN_INV   = (SCAN_ACT_LOW != 0);
  localparam logic             HEX_ON     = (HEX_EN != 0);

  scan_state_e      r_state, w_nxt_state;
  logic [IDX_W-1:0] r_idx, w_nxt_idx;
  logic [7:0]       r_dwell, w_nxt_dwell;
  logic [GAP_W-1:0] r_gap, w_nxt_gap;
  logic [15:0]      r_blink_cnt, w_nxt_blink_cnt;
  logic             r_blink_ph, w_nxt_blink_ph;

  logic [3:0]         w_code;
  logic [6:0]         w_glyph;
  logic [15:0]        w_onehot;
  logic [NUM_DIG-1:0] w_lz_blank;
  logic               w_zero_run;
  logic [NUM_DIG-1:0] w_scan_ah;
  logic [6:0]         w_seg_ah;
  logic               w_dp_ah;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_idx       = r_idx;
    w_nxt_dwell     = r_dwell;
    w_nxt_gap       = r_gap;
    w_nxt_blink_cnt = r_blink_cnt;
    w_nxt_blink_ph  = r_blink_ph;

    if (MS_F) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_nxt_blink_cnt = '0;
        w_nxt_blink_ph  = ~r_blink_ph;
      end else begin
        w_nxt_blink_cnt = r_blink_cnt + 16'd1;
      end
    end

    case (r_state)
      SHOW: begin
        if (MS_F) begin
          if (r_dwell == DWELL_LAST) begin
            w_nxt_dwell = '0;
            w_nxt_idx   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            if (GAP_CYC > 0) begin
              w_nxt_state = GAP;
              w_nxt_gap   = '0;
            end
          end else begin
            w_nxt_dwell = r_dwell + 8'd1;
          end
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_nxt_state = SHOW;
          w_nxt_gap   = '0;
        end else begin
          w_nxt_gap = r_gap + 1'b1;
        end
      end
    endcase
  end

  // Outputs are built from the next state so strobe, segments and DP land together.
  always_comb begin
    w_code     = DIGIT_VAL[{w_nxt_idx, 2'b00} +: 4];
    w_onehot   = f_onehot(4'(w_nxt_idx));
    w_lz_blank = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      w_zero_run    = w_zero_run && (DIGIT_VAL[4*i +: 4] == 4'd0);
      w_lz_blank[i] = LZ_EN && w_zero_run;
    end

    w_scan_ah = '0;
    w_seg_ah  = SEG_BLANK;
    w_dp_ah   = 1'b0;
    if (w_nxt_state == SHOW) begin
      w_scan_ah = NUM_DIG'(w_onehot);
      if (!(w_nxt_blink_ph && BLINK_MASK[w_nxt_idx])) begin
        w_dp_ah  = DP_IN[w_nxt_idx];
        w_seg_ah = w_lz_blank[w_nxt_idx] ? SEG_BLANK : w_glyph;
      end
    end
  end

  seg_glyph_dec u_glyph (
    .i_code   (w_code),
    .i_hex_en (HEX_ON),
    .o_glyph  (w_glyph)
  );

  always_ff @(posedge SYS_CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      r_state     <= SHOW;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_gap       <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      SCAN        <= {NUM_DIG{SCAN_INV}};
      SEVEN_SEG   <= {7{SEG_INV}};
      DISP_DP     <= SEG_INV;
    end else begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      r_dwell     <= w_nxt_dwell;
      r_gap       <= w_nxt_gap;
      r_blink_cnt <= w_nxt_blink_cnt;
      r_blink_ph  <= w_nxt_blink_ph;
      SCAN        <= w_scan_ah ^ {NUM_DIG{SCAN_INV}};
      SEVEN_SEG   <= w_seg_ah ^ {7{SEG_INV}};
      DISP_DP     <= w_dp_ah ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two configurations run side by side against a
// behavioural model of the scan sequence, plus directed glyph/strobe checks.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ms_f;
  logic [23:0] dig;
  logic [5:0]  dp_in;
  logic [5:0]  bmask;
  logic        lz;

  logic [5:0] scan0;
  logic [6:0] seg0;
  logic       dp0;
  logic [3:0] scan1;
  logic [6:0] seg1;
  logic       dp1;

  int checks = 0;
  int errors = 0;

  int nd[2], dwell[2], gapc[2], blnk[2], hex[2], sal[2], scl[2];
  int digit[2], tleft[2], gleft[2], bcnt[2];
  bit dark[2];

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIG(6), .DWELL_TICKS(1), .GAP_CYC(2), .BLINK_TICKS(4),
    .HEX_EN(0), .SEG_ACT_LOW(1), .SCAN_ACT_LOW(1)
  ) dut0 (
    .SYS_CLK(clk), .EXT_RST_N(rst_n), .MS_F(ms_f), .DIGIT_VAL(dig),
    .DP_IN(dp_in), .BLINK_MASK(bmask), .LZ_EN(lz),
    .SCAN(scan0), .SEVEN_SEG(seg0), .DISP_DP(dp0)
  );

  seg_scan_ctrl #(
    .NUM_DIG(4), .DWELL_TICKS(2), .GAP_CYC(0), .BLINK_TICKS(3),
    .HEX_EN(1), .SEG_ACT_LOW(1), .SCAN_ACT_LOW(0)
  ) dut1 (
    .SYS_CLK(clk), .EXT_RST_N(rst_n), .MS_F(ms_f), .DIGIT_VAL(dig[15:0]),
    .DP_IN(dp_in[3:0]), .BLINK_MASK(bmask[3:0]), .LZ_EN(lz),
    .SCAN(scan1), .SEVEN_SEG(seg1), .DISP_DP(dp1)
  );

  function automatic logic [6:0] glyph(input logic [3:0] c, input int hx);
    logic [6:0] g;
    case (c)
      4'd0: g = 7'h3F;  4'd1: g = 7'h06;  4'd2: g = 7'h5B;  4'd3: g = 7'h4F;
      4'd4: g = 7'h66;  4'd5: g = 7'h6D;  4'd6: g = 7'h7D;  4'd7: g = 7'h07;
      4'd8: g = 7'h7F;  4'd9: g = 7'h6F;  4'd10: g = 7'h77; 4'd11: g = 7'h7C;
      4'd12: g = 7'h39; 4'd13: g = 7'h5E; 4'd14: g = 7'h79; default: g = 7'h71;
    endcase
    if (c > 4'd9 && hx == 0) g = 7'h00;
    return g;
  endfunction

  function automatic void mdl_reset(input int k);
    digit[k] = 0;
    tleft[k] = dwell[k];
    gleft[k] = 0;
    bcnt[k]  = 0;
    dark[k]  = 1'b0;
  endfunction

  // Advance one clock: tick-driven blink, dwell countdown, then a dark gap.
  function automatic void mdl_step(input int k, input logic tick);
    if (tick) begin
      bcnt[k]++;
      if (bcnt[k] == blnk[k]) begin
        bcnt[k] = 0;
        dark[k] = !dark[k];
      end
    end
    if (gleft[k] > 0) begin
      gleft[k]--;
    end else if (tick) begin
      tleft[k]--;
      if (tleft[k] == 0) begin
        tleft[k] = dwell[k];
        digit[k] = (digit[k] + 1) % nd[k];
        gleft[k] = gapc[k];
      end
    end
  endfunction

  function automatic void mdl_exp(input int k, output logic [15:0] es,
                                  output logic [6:0] eg, output logic ed);
    logic [15:0] s_ah;
    logic [6:0]  g_ah;
    logic        d_ah;
    logic        blank;
    int d;
    d    = digit[k];
    s_ah = 16'h0;
    g_ah = 7'h00;
    d_ah = 1'b0;
    if (rst_n && gleft[k] == 0) begin
      s_ah = 16'h0001 << d;
      if (!(dark[k] && bmask[d])) begin
        d_ah  = dp_in[d];
        blank = 1'b0;
        if (lz && d > 0) begin
          blank = 1'b1;
          for (int j = d; j < nd[k]; j++)
            if (dig[4*j +: 4] != 4'd0) blank = 1'b0;
        end
        if (!blank) g_ah = glyph(dig[4*d +: 4], hex[k]);
      end
    end
    es = (scl[k] != 0) ? (~s_ah & ((16'h0001 << nd[k]) - 16'h1)) : s_ah;
    eg = (sal[k] != 0) ? ~g_ah : g_ah;
    ed = (sal[k] != 0) ? ~d_ah : d_ah;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [15:0] es0, es1;
    logic [6:0]  eg0, eg1;
    logic        ed0, ed1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) mdl_reset(k);
      else mdl_step(k, ms_f);
    end
    mdl_exp(0, es0, eg0, ed0);
    mdl_exp(1, es1, eg1, ed1);
    @(posedge clk);
    #1;
    chk("scan0", 32'(scan0), 32'(es0));
    chk("seg0", 32'(seg0), 32'(eg0));
    chk("dp0", 32'(dp0), 32'(ed0));
    chk("scan1", 32'(scan1), 32'(es1));
    chk("seg1", 32'(seg1), 32'(eg1));
    chk("dp1", 32'(dp1), 32'(ed1));
  endtask

  task automatic goto_digit(input int k, input int d);
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      ms_f = (c % 3 == 0);
      cyc();
      if (gleft[k] == 0 && digit[k] == d) found = 1'b1;
    end
    ms_f = 1'b0;
    chk("goto_digit", 32'(found), 32'd1);
  endtask

  initial begin
    nd[0] = 6; dwell[0] = 1; gapc[0] = 2; blnk[0] = 4; hex[0] = 0; sal[0] = 1; scl[0] = 1;
    nd[1] = 4; dwell[1] = 2; gapc[1] = 0; blnk[1] = 3; hex[1] = 1; sal[1] = 1; scl[1] = 0;
    mdl_reset(0);
    mdl_reset(1);
    rst_n = 1'b1; ms_f = 1'b0; dig = 24'h123456; dp_in = '0; bmask = '0; lz = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_scan0", 32'(scan0), 32'h3F);
    chk("rst_seg0", 32'(seg0), 32'h7F);
    chk("rst_dp0", 32'(dp0), 32'h1);
    chk("rst_scan1", 32'(scan1), 32'h0);
    repeat (3) cyc();
    #2 rst_n = 1'b1;

    // First scan and the gap before digit 1.
    cyc();
    chk("first_scan", 32'(scan0), 32'h3E);
    chk("first_seg", 32'(seg0), 32'h02);
    ms_f = 1'b1; cyc(); ms_f = 1'b0;
    chk("gap_a_scan", 32'(scan0), 32'h3F);
    cyc();
    chk("gap_b_scan", 32'(scan0), 32'h3F);
    cyc();
    chk("dig1_scan", 32'(scan0), 32'h3D);
    chk("dig1_seg", 32'(seg0), 32'h12);
    for (int a = 0; a < 5; a++) begin
      ms_f = 1'b1; cyc(); ms_f = 1'b0;
      cyc(); cyc(); cyc();
    end
    chk("wrap_scan", 32'(scan0), 32'h3E);
    chk("wrap_seg", 32'(seg0), 32'h02);

    // Leading-zero suppression.
    lz = 1'b1; dig = 24'h000120;
    goto_digit(0, 5); chk("lz_d5", 32'(seg0), 32'h7F); chk("lz_d5_scan", 32'(scan0), 32'h1F);
    goto_digit(0, 4); chk("lz_d4", 32'(seg0), 32'h7F);
    goto_digit(0, 1); chk("lz_d1", 32'(seg0), 32'h24);
    goto_digit(0, 0); chk("lz_d0", 32'(seg0), 32'h40);
    dig = 24'h000000;
    for (int d = 1; d < 6; d++) begin
      goto_digit(0, d); chk("lz_zero_blank", 32'(seg0), 32'h7F);
    end
    goto_digit(0, 0); chk("lz_zero_d0", 32'(seg0), 32'h40);

    // Blink on digit 0 only.
    lz = 1'b0; dig = 24'h000010; dp_in = 6'b000011; bmask = 6'b000001;
    for (int b = 0; b < 8; b++) begin
      goto_digit(0, 0);
      chk("blink_d0_seg", 32'(seg0), dark[0] ? 32'h7F : 32'h40);
      chk("blink_d0_dp", 32'(dp0), dark[0] ? 32'h1 : 32'h0);
      goto_digit(0, 1);
      chk("blink_d1_seg", 32'(seg0), 32'h79);
      chk("blink_d1_dp", 32'(dp0), 32'h0);
    end

    // Hex glyphs enabled on dut1, blanked on dut0.
    bmask = '0; dp_in = '0; dig = 24'h5AF0A3;
    goto_digit(1, 1); chk("hex_a", 32'(seg1), 32'h08); chk("hex_a_scan", 32'(scan1), 32'h2);
    goto_digit(1, 3); chk("hex_f", 32'(seg1), 32'h0E);
    goto_digit(0, 1); chk("nohex_a", 32'(seg0), 32'h7F);
    goto_digit(0, 3); chk("nohex_f", 32'(seg0), 32'h7F);

    // Randomized traffic, including MS_F held high for several cycles.
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        dig = 24'($urandom);
        if ($urandom_range(0, 1) == 0) dig[23:12] = 12'h000;
        if ($urandom_range(0, 2) == 0) dig[11:4] = 8'h00;
      end
      if ($urandom_range(0, 7) == 0) dp_in = 6'($urandom);
      if ($urandom_range(0, 7) == 0) bmask = 6'($urandom);
      if ($urandom_range(0, 15) == 0) lz = ~lz;
      ms_f = ($urandom_range(0, 2) == 0);
      cyc();
    end

    // Asynchronous reset during the gap.
    ms_f = 1'b0; dig = 24'h123456; lz = 1'b0; bmask = '0; dp_in = '0;
    begin
      bit in_gap = 1'b0;
      for (int c = 0; c < 60 && !in_gap; c++) begin
        ms_f = (c % 3 == 0);
        cyc();
        if (gleft[0] > 0) in_gap = 1'b1;
      end
      ms_f = 1'b0;
      chk("reach_gap", 32'(in_gap), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scan0", 32'(scan0), 32'h3F);
    chk("arst_seg0", 32'(seg0), 32'h7F);
    chk("arst_dp0", 32'(dp0), 32'h1);
    chk("arst_scan1", 32'(scan1), 32'h0);
    chk("arst_seg1", 32'(seg1), 32'h7F);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk("restart_scan", 32'(scan0), 32'h3E);
    chk("restart_seg", 32'(seg0), 32'h02);
    chk("restart_scan1", 32'(scan1), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scan controller, NUM_DIG digits wide, for the clock/calendar display path.
- Cycles a one-hot digit strobe at a rate set by the MS_F tick.
- Inserts an anti-ghosting blank gap between digits.
- Adds per-digit blink, leading-zero suppression and optional hex glyphs.
- SCAN, SEVEN_SEG and DISP_DP are registered together, so they are always cycle-aligned.

Parameters:
- NUM_DIG, 6: number of digits, legal range 2..16.
- DWELL_TICKS, 1: MS_F ticks each digit stays lit, legal range 1..255.
- GAP_CYC, 2: SYS_CLK cycles of all-off between digits; 0 means no gap.
- BLINK_TICKS, 250: MS_F ticks per blink half-period, legal range 1..65535.
- HEX_EN, 0: 1 shows A–F for codes 10–15; 0 blanks codes 10–15.
- SEG_ACT_LOW, 1: 1 means a lit segment/DP drives 0.
- SCAN_ACT_LOW, 1: 1 means the selected digit strobe drives 0.

Ports:
- SYS_CLK  in  1  system clock; all state on the rising edge.
- EXT_RST_N  in  1  reset, asynchronous, active-low.
- MS_F  in  1  single-cycle tick enable.
- DIGIT_VAL  in  4*NUM_DIG  BCD/hex code per digit; digit i is at [4i+3:4i]; digit 0 is rightmost.
- DP_IN  in  NUM_DIG  decimal point request per digit.
- BLINK_MASK  in  NUM_DIG  1 = digit blinks.
- LZ_EN  in  1  enable leading-zero suppression.
- SCAN  out  NUM_DIG  one-hot digit strobe, polarity per SCAN_ACT_LOW.
- SEVEN_SEG  out  7  segments g..a at bits [6:0], polarity per SEG_ACT_LOW.
- DISP_DP  out  1  decimal point, polarity per SEG_ACT_LOW.

Behaviour:
- Reset is asynchronous, active-low. While EXT_RST_N=0:
  - All outputs are inactive: SCAN all-off, segments off, DP off.
  - idx=0, state=SHOW, dwell=0, gap=0, blink_ph=0 (on phase).
- States: SHOW and GAP.
- SHOW:
  - SCAN strobes digit idx.
  - Segments and DP come from digit idx.
  - Each MS_F increments dwell. An MS_F arriving when dwell==DWELL_TICKS-1 clears dwell and advances:
    - idx -> idx+1, wrapping NUM_DIG-1 -> 0.
    - If GAP_CYC>0: go to GAP with gap=0.
    - If GAP_CYC=0: stay in SHOW with the new idx.
- GAP:
  - SCAN, segments and DP are all inactive.
  - gap increments every cycle; at gap==GAP_CYC-1, go to SHOW.
  - MS_F does not advance dwell in GAP.
- Output latency: outputs are registered. A change on DIGIT_VAL, DP_IN, BLINK_MASK or LZ_EN is reflected on the next SYS_CLK edge. The new idx appears on the edge after the advancing tick, or after the gap.
- Blink:
  - blink_cnt counts every MS_F in both states.
  - At BLINK_TICKS-1 it clears and toggles blink_ph.
  - While blink_ph=1 and BLINK_MASK[idx]=1: segments and DP are off; SCAN is still strobed.
- Leading-zero suppression: digit i (i>0) is blank when LZ_EN=1 and DIGIT_VAL is 0 for every digit j in i..NUM_DIG-1. Digit 0 is never suppressed. DP_IN still applies to a suppressed digit.
- Glyphs: codes 0–9 are always decoded. Codes 10–15 decode to A,b,C,d,E,F when HEX_EN=1, otherwise to blank.
- Glyph table, active-high, bit0=a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
  - With SEG_ACT_LOW=1 the output is the bitwise inverse.
- Precedence, highest first: GAP, then blink-off, then LZ blank, then glyph.
- Widths:
  - idx: clog2(NUM_DIG) bits.
  - dwell: 8 bits.
  - gap: clog2(GAP_CYC+1) bits, minimum 1.
  - blink_cnt: 16 bits.
  - All counters wrap exactly at their limits, never past them.
- MS_F is a single-cycle pulse. MS_F held high counts once per cycle.
- Reset asserted mid-scan or mid-gap: outputs go inactive immediately (asynchronously). Scan restarts at digit 0 in SHOW on the first edge after release.

Decomposition:
- Package seg_disp_pkg holds:
  - The 16-entry active-high glyph constant table and the SEG_BLANK constant.
  - The state enum {SHOW, GAP}.
  - A function returning a one-hot strobe from an index.
- One sub-module, seg_glyph_dec: combinational code+hex_en -> 7-bit active-high glyph. Polarity is applied in the top level.

Test Plan:
- Reset/first scan. Defaults, DIGIT_VAL=24'h123456, MS_F every 4 cycles.
  - During reset: SCAN=6'h3F, SEVEN_SEG=7'h7F, DISP_DP=1.
  - After release: SCAN=6'h3E with SEVEN_SEG=7'h02 (glyph 6).
  - After the next MS_F: two cycles of SCAN=6'h3F, then SCAN=6'h3D with SEVEN_SEG=7'h12 (glyph 5).
- Full rotation and wrap.
  - Count 6 advances from digit 0; the strobe must return to 6'h3E.
  - Each strobe must show the matching glyph in the same cycle as SCAN.
- Leading zeros. LZ_EN=1, DIGIT_VAL=24'h000120.
  - Digits 5 and 4 show 7'h7F.
  - Digit 0 shows 7'h40.
  - With DIGIT_VAL=0, only digit 0 is lit (7'h40).
- Blink. BLINK_TICKS=4, BLINK_MASK=6'b000001, DP_IN[0]=1.
  - Digit 0 alternates 7'h40/DP=0 and 7'h7F/DP=1 every 4 MS_F ticks.
  - Digit 1 never blanks.
- Hex mode.
  - HEX_EN=1, code A -> 7'h08; code F -> 7'h0E.
  - HEX_EN=0, code A -> 7'h7F.
- Async reset mid-gap.
  - Assert EXT_RST_N=0 between clock edges during GAP; outputs go inactive without waiting for a clock edge.
  - After release, scan restarts at digit 0.
